// File: rtl/looper_jb_pkg.sv
// Shared types and width defaults for the base-jump responder.
package looper_jb_pkg;

  localparam int JB_DATA_W    = 16;
  localparam int JB_REG_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2
  } jb_state_e;

endpackage

// File: rtl/jb_wb_match.sv
// Writeback snoop: compares every writeback port against the pending base
// register and returns the data of the lowest-indexed matching port.
module jb_wb_match
  import looper_jb_pkg::*;
#(
  parameter int DATA_W    = JB_DATA_W,
  parameter int REG_IDX_W = JB_REG_IDX_W,
  parameter int WB_PORTS  = 2
) (
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*REG_IDX_W-1:0] wb_reg,
  input  logic [WB_PORTS*DATA_W-1:0]    wb_data,
  input  logic [REG_IDX_W-1:0]          match_reg,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);

  // Walk ports from highest to lowest so the lowest matching index is written last and wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = WB_PORTS - 1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_reg[i*REG_IDX_W +: REG_IDX_W] == match_reg)) begin
        hit  = 1'b1;
        data = wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/jump_base_server.sv
// Register-file-side responder for register-based jumps. Holds one request,
// waits for the base register to leave the scoreboard, reads it from the RF
// and returns it with a single-cycle jump_base_rdy pulse.
// Build option: define JBASE_WB_BYPASS_EN to capture the base straight from
// a matching writeback bus while waiting (no RF read is issued in that case).
module jump_base_server
  import looper_jb_pkg::*;
#(
  parameter int DATA_W    = JB_DATA_W,
  parameter int REG_IDX_W = JB_REG_IDX_W,
  parameter int WB_PORTS  = 2,
  parameter int WCNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          has_mispredict,
  input  logic                          req_valid,
  input  logic [REG_IDX_W-1:0]          req_reg,
  output logic                          req_ready,
  input  logic [2**REG_IDX_W-1:0]       reg_busy,
  output logic                          rf_rd_en,
  output logic [REG_IDX_W-1:0]          rf_rd_addr,
  input  logic [DATA_W-1:0]             rf_rd_data,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*REG_IDX_W-1:0] wb_reg,
  input  logic [WB_PORTS*DATA_W-1:0]    wb_data,
  output logic [DATA_W-1:0]             jump_base,
  output logic                          jump_base_rdy,
  output logic [WCNT_W-1:0]             wait_cnt
);

  jb_state_e             state_q;
  logic [REG_IDX_W-1:0]  reg_q;
  logic [DATA_W-1:0]     jump_base_q;
  logic                  rdy_q;
  logic [WCNT_W-1:0]     wait_cnt_q;
  logic [WCNT_W-1:0]     wait_cnt_d;

  logic                  bypass_hit;
  logic [DATA_W-1:0]     bypass_data;

  // Counter sticks at all-ones so very long stalls still read as "maximum".
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef JBASE_WB_BYPASS_EN
  jb_wb_match #(
    .DATA_W   (DATA_W),
    .REG_IDX_W(REG_IDX_W),
    .WB_PORTS (WB_PORTS)
  ) u_wb_match (
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .match_reg(reg_q),
    .hit      (bypass_hit),
    .data     (bypass_data)
  );
`else
  assign bypass_hit  = 1'b0;
  assign bypass_data = '0;
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_reg, wb_data};
`endif

  // Handshake and RF strobe decode straight from state; a bypass hit suppresses the read.
  always_comb begin
    req_ready  = (state_q == IDLE);
    rf_rd_en   = (state_q == WAIT) && !reg_busy[reg_q] && !bypass_hit;
    rf_rd_addr = reg_q;
    wait_cnt_d = sat_inc(wait_cnt_q);
  end

  assign jump_base     = jump_base_q;
  assign jump_base_rdy = rdy_q;
  assign wait_cnt      = wait_cnt_q;

  // Request FSM with registered response; flush overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      reg_q       <= '0;
      jump_base_q <= '0;
      rdy_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (has_mispredict) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              reg_q      <= req_reg;
              wait_cnt_q <= '0;
              state_q    <= WAIT;
            end
          end
          WAIT: begin
            wait_cnt_q <= wait_cnt_d;
            if (bypass_hit) begin
              jump_base_q <= bypass_data;
              rdy_q       <= 1'b1;
              state_q     <= IDLE;
            end else if (!reg_busy[reg_q]) begin
              state_q <= READ;
            end
          end
          READ: begin
            jump_base_q <= rf_rd_data;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jump_base_server.sv
// Self-checking bench for jump_base_server: RF model, expected-base scoreboard,
// one task per scenario.
module tb_jump_base_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        has_mispredict;
  logic        req_valid;
  logic [3:0]  req_reg;
  logic        req_ready;
  logic [15:0] reg_busy;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_reg;
  logic [31:0] wb_data;
  logic [15:0] jump_base;
  logic        jump_base_rdy;
  logic [7:0]  wait_cnt;

  logic [15:0] rf_mem [16];
  logic [15:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  jump_base_server dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .has_mispredict(has_mispredict),
    .req_valid     (req_valid),
    .req_reg       (req_reg),
    .req_ready     (req_ready),
    .reg_busy      (reg_busy),
    .rf_rd_en      (rf_rd_en),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .jump_base     (jump_base),
    .jump_base_rdy (jump_base_rdy),
    .wait_cnt      (wait_cnt)
  );

  always #5 clk = ~clk;

  // RF model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; has_mispredict = 0; req_valid = 0; req_reg = 0;
    reg_busy = '0; wb_valid = '0; wb_reg = '0; wb_data = '0; rf_rd_data = '0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h1000 + 16'(i);
    step; step;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++; if (jump_base !== 16'h0) $display("FAIL reset_base: got %h want 0000", jump_base); else pass_cnt++;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", jump_base_rdy); else pass_cnt++;
    total_cnt++; if (wait_cnt !== 8'h0) $display("FAIL reset_wcnt: got %h want 00", wait_cnt); else pass_cnt++;
    total_cnt++; if (rf_rd_en !== 1'b0) $display("FAIL reset_rden: got %b want 0", rf_rd_en); else pass_cnt++;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_basic;
    logic [15:0] exp;
    rf_mem[5] = 16'h1234; reg_busy = '0;
    req_valid = 1; req_reg = 4'd5; exp_q.push_back(16'h1234);
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", req_ready); else pass_cnt++;
    step; req_valid = 0; #1;
    total_cnt++; if (rf_rd_en !== 1'b1) $display("FAIL basic_rden_n1: got %b want 1", rf_rd_en); else pass_cnt++;
    total_cnt++; if (rf_rd_addr !== 4'd5) $display("FAIL basic_addr: got %0d want 5", rf_rd_addr); else pass_cnt++;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL basic_rdy_n1: got %b want 0", jump_base_rdy); else pass_cnt++;
    step;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL basic_rdy_n2: got %b want 0", jump_base_rdy); else pass_cnt++;
    total_cnt++; if (rf_rd_en !== 1'b0) $display("FAIL basic_rden_n2: got %b want 0", rf_rd_en); else pass_cnt++;
    step;
    total_cnt++; if (jump_base_rdy !== 1'b1) $display("FAIL basic_rdy_n3: got %b want 1", jump_base_rdy); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (jump_base !== exp) $display("FAIL basic_data: got %h want %h", jump_base, exp); else pass_cnt++;
    step;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL basic_rdy_n4: got %b want 0", jump_base_rdy); else pass_cnt++;
    total_cnt++; if (jump_base !== 16'h1234) $display("FAIL basic_hold: got %h want 1234", jump_base); else pass_cnt++;
  endtask

  task automatic test_busy_wait;
    logic [15:0] exp;
    int bad;
    rf_mem[3] = 16'h00F0; reg_busy = '0; reg_busy[3] = 1'b1;
    req_valid = 1; req_reg = 4'd3; exp_q.push_back(16'h00F0);
    step; req_valid = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) step;
      if (rf_rd_en !== 1'b0 || jump_base_rdy !== 1'b0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL busy_stall: got %0d early reads/pulses want 0", bad); else pass_cnt++;
    step; reg_busy[3] = 1'b0; #1;
    total_cnt++; if (rf_rd_en !== 1'b1) $display("FAIL busy_rden: got %b want 1", rf_rd_en); else pass_cnt++;
    step;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL busy_rdy_early: got %b want 0", jump_base_rdy); else pass_cnt++;
    step;
    total_cnt++; if (jump_base_rdy !== 1'b1) $display("FAIL busy_rdy: got %b want 1", jump_base_rdy); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (jump_base !== exp) $display("FAIL busy_data: got %h want %h", jump_base, exp); else pass_cnt++;
    total_cnt++; if (wait_cnt !== 8'd7) $display("FAIL busy_wcnt: got %0d want 7", wait_cnt); else pass_cnt++;
    step;
  endtask

  task automatic test_mispredict;
    logic [15:0] exp;
    int pulses;
    bit got;
    rf_mem[2] = 16'hBEEF; rf_mem[4] = 16'h4444; reg_busy = '0;
    req_valid = 1; req_reg = 4'd2;
    step; req_valid = 0; #1;
    total_cnt++; if (rf_rd_en !== 1'b1) $display("FAIL misp_rden: got %b want 1", rf_rd_en); else pass_cnt++;
    has_mispredict = 1;
    step; has_mispredict = 0; #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL misp_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL misp_rdy: got %b want 0", jump_base_rdy); else pass_cnt++;
    total_cnt++; if (jump_base !== 16'h00F0) $display("FAIL misp_hold: got %h want 00F0", jump_base); else pass_cnt++;
    req_valid = 1; req_reg = 4'd4; exp_q.push_back(16'h4444);
    pulses = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step; req_valid = 0;
      if (jump_base_rdy) begin got = 1; pulses++; end
    end
    total_cnt++; if (!got) $display("FAIL misp_new_timeout: got no rdy want rdy within 10 cycles"); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (jump_base !== exp) $display("FAIL misp_new_data: got %h want %h", jump_base, exp); else pass_cnt++;
    step;
  endtask

  task automatic test_ignore_second;
    logic [15:0] exp;
    logic [15:0] seen;
    int pulses;
    rf_mem[6] = 16'h6666; rf_mem[9] = 16'h9999; reg_busy = '0; reg_busy[6] = 1'b1;
    req_valid = 1; req_reg = 4'd6; exp_q.push_back(16'h6666);
    step; req_reg = 4'd9; #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL ign_ready: got %b want 0", req_ready); else pass_cnt++;
    step; step; req_valid = 0; reg_busy[6] = 1'b0;
    pulses = 0; seen = 16'hxxxx;
    for (int i = 0; i < 10; i++) begin
      step;
      if (jump_base_rdy) begin pulses++; seen = jump_base; end
    end
    total_cnt++; if (pulses != 1) $display("FAIL ign_pulses: got %0d want 1", pulses); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (seen !== exp) $display("FAIL ign_data: got %h want %h", seen, exp); else pass_cnt++;
  endtask

  task automatic test_wb;
    logic [15:0] exp;
    bit got;
    int reads;
    rf_mem[7] = 16'h7777; reg_busy = '0; reg_busy[7] = 1'b1;
    req_valid = 1; req_reg = 4'd7;
    step; req_valid = 0;
    wb_valid = 2'b11; wb_reg = {4'd7, 4'd7}; wb_data = {16'hBBBB, 16'hAAAA};
    #1;
    total_cnt++; if (rf_rd_en !== 1'b0) $display("FAIL wb_rden: got %b want 0", rf_rd_en); else pass_cnt++;
`ifdef JBASE_WB_BYPASS_EN
    exp_q.push_back(16'hAAAA);
    step; wb_valid = '0;
    total_cnt++; if (jump_base_rdy !== 1'b1) $display("FAIL wb_rdy: got %b want 1", jump_base_rdy); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (jump_base !== exp) $display("FAIL wb_data: got %h want %h", jump_base, exp); else pass_cnt++;
    reg_busy[7] = 1'b0;
    step;
`else
    exp_q.push_back(16'h7777);
    reads = 0; got = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (jump_base_rdy || rf_rd_en) got = 1;
    end
    total_cnt++; if (got) $display("FAIL wb_ignored: got early response want none while busy"); else pass_cnt++;
    wb_valid = '0; reg_busy[7] = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (jump_base_rdy) got = 1;
    end
    total_cnt++; if (!got) $display("FAIL wb_rf_timeout: got no rdy want rdy within 10 cycles"); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (jump_base !== exp) $display("FAIL wb_rf_data: got %h want %h", jump_base, exp); else pass_cnt++;
    step;
`endif
  endtask

  task automatic test_async_reset;
    int pulses;
    rf_mem[8] = 16'h8888; reg_busy = '0;
    req_valid = 1; req_reg = 4'd8;
    step; req_valid = 0;
    step;
    rst_n = 1'b0; #1;
    total_cnt++; if (jump_base_rdy !== 1'b0) $display("FAIL arst_rdy: got %b want 0", jump_base_rdy); else pass_cnt++;
    total_cnt++; if (jump_base !== 16'h0) $display("FAIL arst_base: got %h want 0000", jump_base); else pass_cnt++;
    total_cnt++; if (wait_cnt !== 8'h0) $display("FAIL arst_wcnt: got %h want 00", wait_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL arst_idle: got %b want 1", req_ready); else pass_cnt++;
    step; rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (jump_base_rdy) pulses++;
    end
    total_cnt++; if (pulses != 0) $display("FAIL arst_nopulse: got %0d pulses want 0", pulses); else pass_cnt++;
  endtask

  task automatic test_saturate_reg0;
    logic [15:0] exp;
    bit got;
    rf_mem[0] = 16'h0F0F; reg_busy = '0; reg_busy[0] = 1'b1;
    req_valid = 1; req_reg = 4'd0; exp_q.push_back(16'h0F0F);
    step; req_valid = 0;
    for (int i = 0; i < 300; i++) step;
    reg_busy[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (jump_base_rdy) got = 1;
    end
    total_cnt++; if (!got) $display("FAIL sat_timeout: got no rdy want rdy within 10 cycles"); else pass_cnt++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    total_cnt++; if (jump_base !== exp) $display("FAIL sat_data: got %h want %h", jump_base, exp); else pass_cnt++;
    total_cnt++; if (wait_cnt !== 8'hFF) $display("FAIL sat_wcnt: got %h want ff", wait_cnt); else pass_cnt++;
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_busy_wait;
    test_mispredict;
    test_ignore_second;
    test_wb;
    test_async_reset;
    test_saturate_reg0;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
